meta_chooser_table: RTL



---
 rtl/meta_pred_pkg.sv | 34 +++
 rtl/meta_chooser_table_if.sv | 49 ++++
 rtl/meta_init_sweeper.sv | 38 +++
 rtl/meta_chooser_table.sv | 133 +++++++++++++
 4 files changed

// File: rtl/meta_pred_pkg.sv
// Shared types and helpers for the meta (global/local) chooser table.
// Holds the FSM state enum, default geometry and the saturating counter update.
package meta_pred_pkg;

  localparam int DEF_IDX_W = 10;
  localparam int DEF_CTR_W = 2;
  localparam int MAX_CTR_W = 4;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } meta_state_e;

  localparam logic [MAX_CTR_W-1:0] CTR_ONE = MAX_CTR_W'(1);

  // Trains toward global when only global was right, toward local when only local was right.
  // Callers pass their own counter maximum so one function serves every CTR_W.
  function automatic logic [MAX_CTR_W-1:0] sat_update(
    input logic [MAX_CTR_W-1:0] cur,
    input logic [MAX_CTR_W-1:0] max_val,
    input logic                 glob_ok,
    input logic                 loc_ok
  );
    logic [MAX_CTR_W-1:0] res;
    res = cur;
    if (glob_ok && !loc_ok && (cur != max_val)) begin
      res = cur + CTR_ONE;
    end else if (loc_ok && !glob_ok && (cur != '0)) begin
      res = cur - CTR_ONE;
    end
    return res;
  endfunction

endpackage

// File: rtl/meta_chooser_table_if.sv
// Lookup / training bus of the meta chooser table.
// master = predictor pipeline driving requests, slave = the table.
interface meta_chooser_table_if
  import meta_pred_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int CTR_W = DEF_CTR_W
);

  logic             ready;

  logic             rd_valid;
  logic [IDX_W-1:0] rd_idx;
  logic             pred_valid;
  logic             pred_use_global;
  logic [CTR_W-1:0] pred_ctr;

  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_global_correct;
  logic             upd_local_correct;

  modport master (
    input  ready,
    output rd_valid,
    output rd_idx,
    input  pred_valid,
    input  pred_use_global,
    input  pred_ctr,
    output upd_valid,
    output upd_idx,
    output upd_global_correct,
    output upd_local_correct
  );

  modport slave (
    output ready,
    input  rd_valid,
    input  rd_idx,
    output pred_valid,
    output pred_use_global,
    output pred_ctr,
    input  upd_valid,
    input  upd_idx,
    input  upd_global_correct,
    input  upd_local_correct
  );

endinterface

// File: rtl/meta_init_sweeper.sv
// Walks the table index from 0 to the last entry while enabled, one entry per cycle.
// done_o marks the cycle in which the final entry is being written.
module meta_init_sweeper
  import meta_pred_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [IDX_W-1:0] ptr_o,
  output logic             done_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = ptr_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o  = ptr_q;
  assign done_o = en_i && (ptr_q == LAST_IDX);

endmodule

// File: rtl/meta_chooser_table.sv
// Tournament-predictor chooser table: 2**IDX_W saturating counters, swept to INIT_VAL after reset.
// Define META_CHOOSER_BYPASS_EN to forward a same-cycle same-index update into the lookup result.
module meta_chooser_table
  import meta_pred_pkg::*;
#(
  parameter int IDX_W    = DEF_IDX_W,
  parameter int CTR_W    = DEF_CTR_W,
  parameter int INIT_VAL = 2**(CTR_W-1)-1
) (
  input  logic                 clk,
  input  logic                 rst,
  meta_chooser_table_if.slave  bus
);

  localparam int               DEPTH    = 2**IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] INIT_CTR = CTR_W'(INIT_VAL);

  meta_state_e      state_q;
  meta_state_e      state_d;

  logic [CTR_W-1:0] mem_q [DEPTH];

  logic             sweep_en;
  logic [IDX_W-1:0] sweep_ptr;
  logic             sweep_last;

  logic             ready;
  logic             rd_fire;
  logic             upd_fire;
  logic [CTR_W-1:0] upd_cur;
  logic [CTR_W-1:0] upd_new;
  logic [CTR_W-1:0] rd_val;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [CTR_W-1:0] wr_val;

  logic             pred_valid_q;
  logic             pred_valid_d;
  logic [CTR_W-1:0] pred_ctr_q;
  logic [CTR_W-1:0] pred_ctr_d;

  assign ready    = (state_q == READY);
  assign sweep_en = (state_q == INIT);

  meta_init_sweeper #(
    .IDX_W (IDX_W)
  ) u_sweeper (
    .clk    (clk),
    .rst    (rst),
    .en_i   (sweep_en),
    .ptr_o  (sweep_ptr),
    .done_o (sweep_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (sweep_last) state_d = READY;
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Requests arriving with rst are dropped so a reset edge never trains the table.
  assign rd_fire  = bus.rd_valid  && ready && !rst;
  assign upd_fire = bus.upd_valid && ready && !rst;

  assign upd_cur = mem_q[bus.upd_idx];
  assign upd_new = CTR_W'(sat_update(MAX_CTR_W'(upd_cur), MAX_CTR_W'(CTR_MAX),
                                     bus.upd_global_correct, bus.upd_local_correct));

  // Single write port: the sweep owns it during INIT, training owns it in READY.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = sweep_ptr;
    wr_val = INIT_CTR;
    if (!rst) begin
      if (sweep_en) begin
        wr_en = 1'b1;
      end else if (upd_fire) begin
        wr_en  = 1'b1;
        wr_idx = bus.upd_idx;
        wr_val = upd_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_val;
    end
  end

`ifdef META_CHOOSER_BYPASS_EN
  assign rd_val = (upd_fire && (bus.upd_idx == bus.rd_idx)) ? upd_new : mem_q[bus.rd_idx];
`else
  assign rd_val = mem_q[bus.rd_idx];
`endif

  always_comb begin
    pred_valid_d = rd_fire;
    pred_ctr_d   = pred_ctr_q;
    if (rd_fire) begin
      pred_ctr_d = rd_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_q <= 1'b0;
      pred_ctr_q   <= '0;
    end else begin
      pred_valid_q <= pred_valid_d;
      pred_ctr_q   <= pred_ctr_d;
    end
  end

  assign bus.ready           = ready;
  assign bus.pred_valid      = pred_valid_q;
  assign bus.pred_ctr        = pred_ctr_q;
  assign bus.pred_use_global = pred_ctr_q[CTR_W-1];

endmodule
